hazard_scoreboard: RTL

Parametrised successor to the ID-stage hazard detector. It tracks in-flight destination registers internally in an EXE/MEM shadow pipeline rather than taking them from the stage registers. It raises the ID stall, and delivers registered per-source forwarding selects aligned with the instruction as it enters EXE. It sits beside the ID/EXE stage register and is driven by the same freeze and flush as the datapath.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_src_match.sv | 24 ++
 rtl/hazard_scoreboard.sv | 121 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: forwarding select encoding and the
// per-stage shadow slot that records an in-flight destination register.
package hazard_pkg;

  // Slots are sized for the widest supported register file; narrower REG_W
  // values are zero-extended on the way in.
  localparam int unsigned SLOT_REG_W = 8;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic                  valid;
    logic [SLOT_REG_W-1:0] dest;
    logic                  wb_en;
    logic                  mem_r_en;
  } slot_t;

endpackage

// File: rtl/hazard_src_match.sv
// Single source operand versus single shadow slot dependency comparator.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W     = 4,
  parameter bit          IGNORE_R0 = 1'b0
) (
  input  logic             id_valid_i,
  input  logic             src_used_i,
  input  logic [REG_W-1:0] src_i,
  input  slot_t            slot_i,
  output logic             match_o
);

  logic [SLOT_REG_W-1:0] src_ext;
  logic                  r0_masked;

  assign src_ext   = SLOT_REG_W'(src_i);
  assign r0_masked = IGNORE_R0 && (slot_i.dest == '0);

  assign match_o = id_valid_i & src_used_i & slot_i.valid & slot_i.wb_en &
                   (src_ext == slot_i.dest) & ~r0_masked;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard with an internal EXE/MEM shadow pipeline and
// registered per-operand forwarding selects. HAZARD_STATS_EN adds stall_count.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W     = 4,
  parameter int unsigned NUM_SRC   = 2,
  parameter bit          IGNORE_R0 = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     freeze,
  input  logic                     flush,
  input  logic                     en_fwd,
  input  logic                     id_valid,
  input  logic [NUM_SRC*REG_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]       id_src_used,
  input  logic [REG_W-1:0]         id_dest,
  input  logic                     id_wb_en,
  input  logic                     id_mem_r_en,
  output logic                     hazard_detected,
  output logic [2*NUM_SRC-1:0]     exe_fwd_sel
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]              stall_count
`endif
);

  slot_t                exe_q, exe_d, mem_q;
  logic [NUM_SRC-1:0]   match_exe, match_mem;
  logic [2*NUM_SRC-1:0] fwd_q, fwd_d;
  logic                 load_id;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    hazard_src_match #(
      .REG_W    (REG_W),
      .IGNORE_R0(IGNORE_R0)
    ) u_match_exe (
      .id_valid_i(id_valid),
      .src_used_i(id_src_used[s]),
      .src_i     (id_src[s*REG_W +: REG_W]),
      .slot_i    (exe_q),
      .match_o   (match_exe[s])
    );

    hazard_src_match #(
      .REG_W    (REG_W),
      .IGNORE_R0(IGNORE_R0)
    ) u_match_mem (
      .id_valid_i(id_valid),
      .src_used_i(id_src_used[s]),
      .src_i     (id_src[s*REG_W +: REG_W]),
      .slot_i    (mem_q),
      .match_o   (match_mem[s])
    );
  end

  // With forwarding only a load still in EXE cannot supply its result in time.
  always_comb begin
    if (en_fwd) begin
      hazard_detected = exe_q.mem_r_en & (|match_exe);
    end else begin
      hazard_detected = (|match_exe) | (|match_mem);
    end
  end

  assign load_id = id_valid & ~hazard_detected & ~flush;

  always_comb begin
    exe_d = '0;
    if (load_id) begin
      exe_d.valid    = 1'b1;
      exe_d.dest     = SLOT_REG_W'(id_dest);
      exe_d.wb_en    = id_wb_en;
      exe_d.mem_r_en = id_mem_r_en;
    end
  end

  // Nearest producer wins: an EXE match shadows an older MEM match.
  always_comb begin
    fwd_d = '0;
    if (en_fwd && load_id) begin
      for (int s = 0; s < int'(NUM_SRC); s++) begin
        if (match_exe[s]) begin
          fwd_d[2*s +: 2] = FWD_MEM;
        end else if (match_mem[s]) begin
          fwd_d[2*s +: 2] = FWD_WB;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_q <= '0;
      mem_q <= '0;
      fwd_q <= '0;
    end else if (!freeze) begin
      mem_q <= exe_q;
      exe_q <= exe_d;
      fwd_q <= fwd_d;
    end
  end

  assign exe_fwd_sel = fwd_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= '0;
    end else if (hazard_detected && !freeze && (stall_count_q != '1)) begin
      stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule
